mmu_rsp_arbiter: RTL and testbench

- Merges the two producers of each MMU response stream into a single writer per response FIFO. The alloc stream is fed by dispatcher fail responses and FDT alloc results; the free stream is fed by dispatcher fail responses and or_tree free completions.
- Producers issue single-cycle, non-backpressurable write pulses, so each producer gets a small pending queue.
- A per-channel round-robin arbiter drains the queues into the alloc/free response FIFOs, honouring FIFO full.

---
 rtl/mmu_rsp_arbiter_pkg.sv | 65 ++++++
 rtl/mmu_rsp_pend_fifo.sv | 68 ++++++
 rtl/mmu_rsp_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mmu_rsp_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_rsp_arbiter_pkg.sv
// Shared widths, source encodings and entry layouts for the MMU response arbiter.
// The width macros and reason codes are the usual mmu_param.vh definitions. They
// are guarded so that including the real header first takes precedence.
`ifndef MMU_PARAM_VH
`define MMU_PARAM_VH
`define REQ_ID_WIDTH        8
`define ALL_PAGE_IDX_WIDTH  8
`define FAIL_REASON_WIDTH   3
`define FAIL_NONE           3'd0
`define FAIL_NO_SPACE       3'd1
`define FAIL_BAD_ID         3'd2
`define FAIL_NOT_ALLOC      3'd3
`endif

`ifndef RSP_SRC_DISP
`define RSP_SRC_DISP 1'b0
`endif
`ifndef RSP_SRC_ENG
`define RSP_SRC_ENG  1'b1
`endif

package mmu_rsp_arbiter_pkg;

  localparam int REQ_ID_W = `REQ_ID_WIDTH;
  localparam int PAGE_W   = `ALL_PAGE_IDX_WIDTH;
  localparam int REASON_W = `FAIL_REASON_WIDTH;

  // Which producer of a channel an entry came from.
  typedef enum logic {
    SRC_DISP = `RSP_SRC_DISP,
    SRC_ENG  = `RSP_SRC_ENG
  } rsp_src_e;

  // Alloc responses carry the allocated page index.
  typedef struct packed {
    logic [REQ_ID_W-1:0] id;
    logic [PAGE_W-1:0]   page_idx;
    logic                fail;
    logic [REASON_W-1:0] reason;
  } alloc_entry_t;

  // Free responses have no page index.
  typedef struct packed {
    logic [REQ_ID_W-1:0] id;
    logic                fail;
    logic [REASON_W-1:0] reason;
  } free_entry_t;

  localparam int ALLOC_ENTRY_W = $bits(alloc_entry_t);
  localparam int FREE_ENTRY_W  = $bits(free_entry_t);

  // Two-way round robin: alternate when both sources wait, otherwise take the
  // only one that has something.
  function automatic rsp_src_e rr_pick(input logic disp_ne, input logic eng_ne,
                                       input rsp_src_e last_grant);
    if (disp_ne && eng_ne) begin
      return (last_grant == SRC_DISP) ? SRC_ENG : SRC_DISP;
    end else if (disp_ne) begin
      return SRC_DISP;
    end else begin
      return SRC_ENG;
    end
  endfunction

endpackage

// File: rtl/mmu_rsp_pend_fifo.sv
// Small pending queue in front of the response arbiter. Producers cannot be
// stalled, so a push into a full queue without a simultaneous pop is dropped
// and flagged for one cycle on drop. dout shows the head entry without a read
// latency so the arbiter can register it in the pop cycle.
module mmu_rsp_pend_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam logic [PTR_WIDTH-1:0] PTR_ONE   = {{(PTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH:0]   CNT_ONE   = {{PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH:0]   CNT_DEPTH = DEPTH[PTR_WIDTH:0];

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_reg;
  logic [PTR_WIDTH-1:0] rd_ptr_reg;
  logic [PTR_WIDTH:0]   count_reg;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_DEPTH);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign dout    = mem[rd_ptr_reg];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy tracking; pointers wrap by natural rollover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mmu_rsp_arbiter.sv
// Merges the dispatcher and engine producers of each MMU response stream into
// one writer per response FIFO. Each producer has its own pending queue; a
// per-channel round robin drains them into registered write ports.
module mmu_rsp_arbiter
  import mmu_rsp_arbiter_pkg::*;
#(
  parameter int PEND_DEPTH     = 4,
  parameter int PEND_PTR_WIDTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                disp_alloc_valid,
  input  logic [REQ_ID_W-1:0] disp_alloc_id,
  input  logic [PAGE_W-1:0]   disp_alloc_page_idx,
  input  logic                disp_alloc_fail,
  input  logic [REASON_W-1:0] disp_alloc_reason,
  input  logic                fdt_alloc_valid,
  input  logic [REQ_ID_W-1:0] fdt_alloc_id,
  input  logic [PAGE_W-1:0]   fdt_alloc_page_idx,
  input  logic                fdt_alloc_fail,
  input  logic [REASON_W-1:0] fdt_alloc_reason,
  input  logic                disp_free_valid,
  input  logic [REQ_ID_W-1:0] disp_free_id,
  input  logic                disp_free_fail,
  input  logic [REASON_W-1:0] disp_free_reason,
  input  logic                ortree_free_valid,
  input  logic [REQ_ID_W-1:0] ortree_free_id,
  input  logic                ortree_free_fail,
  input  logic [REASON_W-1:0] ortree_free_reason,
  output logic                alloc_rsp_write_en,
  output logic [REQ_ID_W-1:0] alloc_rsp_id,
  output logic [PAGE_W-1:0]   alloc_rsp_page_idx,
  output logic                alloc_rsp_fail,
  output logic [REASON_W-1:0] alloc_rsp_fail_reason,
  input  logic                alloc_rsp_fifo_full,
  output logic                free_rsp_write_en,
  output logic [REQ_ID_W-1:0] free_rsp_id,
  output logic                free_rsp_fail,
  output logic [REASON_W-1:0] free_rsp_fail_reason,
  input  logic                free_rsp_fifo_full,
  output logic [3:0]          overflow_err,
  output logic                arb_idle
);

  // Queue index 0 is the dispatcher, 1 is the engine (FDT / or_tree).
  logic [1:0]   alloc_push, alloc_pop, alloc_empty, alloc_full, alloc_drop;
  logic [1:0]   free_push, free_pop, free_empty, free_full, free_drop;
  alloc_entry_t alloc_din  [2];
  alloc_entry_t alloc_dout [2];
  free_entry_t  free_din   [2];
  free_entry_t  free_dout  [2];

  rsp_src_e     alloc_grant, free_grant;
  logic         alloc_fire, free_fire;
  alloc_entry_t alloc_sel;
  free_entry_t  free_sel;

  rsp_src_e     alloc_last_reg, free_last_reg;
  logic         alloc_we_reg, free_we_reg;
  alloc_entry_t alloc_out_reg;
  free_entry_t  free_out_reg;
  logic [3:0]   overflow_reg;

  // Queue-full indications are not needed: drops are reported by the queues.
  logic         unused_full;
  assign unused_full = ^{alloc_full, free_full};

  assign alloc_push = {fdt_alloc_valid, disp_alloc_valid};
  assign free_push  = {ortree_free_valid, disp_free_valid};

  assign alloc_din[0] = '{id: disp_alloc_id, page_idx: disp_alloc_page_idx,
                          fail: disp_alloc_fail, reason: disp_alloc_reason};
  assign alloc_din[1] = '{id: fdt_alloc_id, page_idx: fdt_alloc_page_idx,
                          fail: fdt_alloc_fail, reason: fdt_alloc_reason};
  assign free_din[0]  = '{id: disp_free_id, fail: disp_free_fail,
                          reason: disp_free_reason};
  assign free_din[1]  = '{id: ortree_free_id, fail: ortree_free_fail,
                          reason: ortree_free_reason};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_queue
      mmu_rsp_pend_fifo #(
        .WIDTH     (ALLOC_ENTRY_W),
        .DEPTH     (PEND_DEPTH),
        .PTR_WIDTH (PEND_PTR_WIDTH)
      ) u_alloc_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (alloc_push[gi]),
        .pop   (alloc_pop[gi]),
        .din   (alloc_din[gi]),
        .dout  (alloc_dout[gi]),
        .empty (alloc_empty[gi]),
        .full  (alloc_full[gi]),
        .drop  (alloc_drop[gi])
      );

      mmu_rsp_pend_fifo #(
        .WIDTH     (FREE_ENTRY_W),
        .DEPTH     (PEND_DEPTH),
        .PTR_WIDTH (PEND_PTR_WIDTH)
      ) u_free_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (free_push[gi]),
        .pop   (free_pop[gi]),
        .din   (free_din[gi]),
        .dout  (free_dout[gi]),
        .empty (free_empty[gi]),
        .full  (free_full[gi]),
        .drop  (free_drop[gi])
      );
    end
  endgenerate

  // Alloc channel grant: pop one queue whenever the response FIFO has room.
  always_comb begin
    alloc_grant = rr_pick(!alloc_empty[0], !alloc_empty[1], alloc_last_reg);
    alloc_fire  = !alloc_rsp_fifo_full && !(&alloc_empty);
    alloc_sel   = (alloc_grant == SRC_ENG) ? alloc_dout[1] : alloc_dout[0];
    alloc_pop   = 2'b00;
    if (alloc_fire) begin
      alloc_pop = (alloc_grant == SRC_ENG) ? 2'b10 : 2'b01;
    end
  end

  // Free channel grant, identical policy and independent of the alloc side.
  always_comb begin
    free_grant = rr_pick(!free_empty[0], !free_empty[1], free_last_reg);
    free_fire  = !free_rsp_fifo_full && !(&free_empty);
    free_sel   = (free_grant == SRC_ENG) ? free_dout[1] : free_dout[0];
    free_pop   = 2'b00;
    if (free_fire) begin
      free_pop = (free_grant == SRC_ENG) ? 2'b10 : 2'b01;
    end
  end

  // Alloc output register and pointer; last grant starts at the engine so the
  // dispatcher wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_we_reg   <= 1'b0;
      alloc_out_reg  <= '0;
      alloc_last_reg <= SRC_ENG;
    end else begin
      alloc_we_reg  <= alloc_fire;
      alloc_out_reg <= alloc_fire ? alloc_sel : '0;
      if (alloc_fire) begin
        alloc_last_reg <= alloc_grant;
      end
    end
  end

  // Free output register and pointer, same reset preference as alloc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_we_reg   <= 1'b0;
      free_out_reg  <= '0;
      free_last_reg <= SRC_ENG;
    end else begin
      free_we_reg  <= free_fire;
      free_out_reg <= free_fire ? free_sel : '0;
      if (free_fire) begin
        free_last_reg <= free_grant;
      end
    end
  end

  // Sticky per-queue drop flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg <= '0;
    end else begin
      overflow_reg <= overflow_reg | {free_drop, alloc_drop};
    end
  end

  assign alloc_rsp_write_en    = alloc_we_reg;
  assign alloc_rsp_id          = alloc_out_reg.id;
  assign alloc_rsp_page_idx    = alloc_out_reg.page_idx;
  assign alloc_rsp_fail        = alloc_out_reg.fail;
  assign alloc_rsp_fail_reason = alloc_out_reg.reason;

  assign free_rsp_write_en     = free_we_reg;
  assign free_rsp_id           = free_out_reg.id;
  assign free_rsp_fail         = free_out_reg.fail;
  assign free_rsp_fail_reason  = free_out_reg.reason;

  assign overflow_err = overflow_reg;
  assign arb_idle     = (&alloc_empty) && (&free_empty) && !alloc_we_reg && !free_we_reg;

endmodule

// File: tb/tb_mmu_rsp_arbiter.sv
// Scoreboard bench for mmu_rsp_arbiter: a queue-level model predicts which
// entry each channel writes and in which cycle; a monitor compares every cycle.
module tb_mmu_rsp_arbiter;
  import mmu_rsp_arbiter_pkg::*;

  localparam int IW    = REQ_ID_W;
  localparam int PW    = PAGE_W;
  localparam int RW    = REASON_W;
  localparam int EW    = IW + PW + 1 + RW;
  localparam int DEPTH = 4;

  logic          clk, rst_n;
  logic          disp_alloc_valid, fdt_alloc_valid, disp_free_valid, ortree_free_valid;
  logic [IW-1:0] disp_alloc_id, fdt_alloc_id, disp_free_id, ortree_free_id;
  logic [PW-1:0] disp_alloc_page_idx, fdt_alloc_page_idx;
  logic          disp_alloc_fail, fdt_alloc_fail, disp_free_fail, ortree_free_fail;
  logic [RW-1:0] disp_alloc_reason, fdt_alloc_reason, disp_free_reason, ortree_free_reason;
  logic          alloc_rsp_write_en, alloc_rsp_fail, alloc_rsp_fifo_full;
  logic [IW-1:0] alloc_rsp_id, free_rsp_id;
  logic [PW-1:0] alloc_rsp_page_idx;
  logic [RW-1:0] alloc_rsp_fail_reason, free_rsp_fail_reason;
  logic          free_rsp_write_en, free_rsp_fail, free_rsp_fifo_full;
  logic [3:0]    overflow_err;
  logic          arb_idle;

  mmu_rsp_arbiter #(.PEND_DEPTH(4), .PEND_PTR_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_alloc_valid(disp_alloc_valid), .disp_alloc_id(disp_alloc_id),
    .disp_alloc_page_idx(disp_alloc_page_idx), .disp_alloc_fail(disp_alloc_fail),
    .disp_alloc_reason(disp_alloc_reason),
    .fdt_alloc_valid(fdt_alloc_valid), .fdt_alloc_id(fdt_alloc_id),
    .fdt_alloc_page_idx(fdt_alloc_page_idx), .fdt_alloc_fail(fdt_alloc_fail),
    .fdt_alloc_reason(fdt_alloc_reason),
    .disp_free_valid(disp_free_valid), .disp_free_id(disp_free_id),
    .disp_free_fail(disp_free_fail), .disp_free_reason(disp_free_reason),
    .ortree_free_valid(ortree_free_valid), .ortree_free_id(ortree_free_id),
    .ortree_free_fail(ortree_free_fail), .ortree_free_reason(ortree_free_reason),
    .alloc_rsp_write_en(alloc_rsp_write_en), .alloc_rsp_id(alloc_rsp_id),
    .alloc_rsp_page_idx(alloc_rsp_page_idx), .alloc_rsp_fail(alloc_rsp_fail),
    .alloc_rsp_fail_reason(alloc_rsp_fail_reason), .alloc_rsp_fifo_full(alloc_rsp_fifo_full),
    .free_rsp_write_en(free_rsp_write_en), .free_rsp_id(free_rsp_id),
    .free_rsp_fail(free_rsp_fail), .free_rsp_fail_reason(free_rsp_fail_reason),
    .free_rsp_fifo_full(free_rsp_fifo_full),
    .overflow_err(overflow_err), .arb_idle(arb_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: queue 0 disp_alloc, 1 fdt_alloc, 2 disp_free, 3 ortree_free.
  typedef struct {
    int            cyc;
    logic [EW-1:0] d;
  } exp_t;

  logic [EW-1:0] mq [4][$];
  exp_t          exp_q [2][$];
  logic [1:0]    last_eng = 2'b11;   // per channel: engine queue granted last
  logic [3:0]    ovf_m = '0;
  logic [3:0]    nx_v = '0;
  logic [EW-1:0] nx_d [4];
  logic [1:0]    full_m = '0;

  task automatic set_push(input int i, input logic [IW-1:0] id, input logic [PW-1:0] pg,
                          input logic f, input logic [RW-1:0] r);
    nx_v[i] = 1'b1;
    nx_d[i] = {id, pg, f, r};
  endtask

  // One clock cycle: drive the staged inputs and advance the model.
  task automatic tick();
    logic [EW-1:0] d;
    int g;
    @(negedge clk);
    disp_alloc_valid = nx_v[0];
    {disp_alloc_id, disp_alloc_page_idx, disp_alloc_fail, disp_alloc_reason} = nx_d[0];
    fdt_alloc_valid = nx_v[1];
    {fdt_alloc_id, fdt_alloc_page_idx, fdt_alloc_fail, fdt_alloc_reason} = nx_d[1];
    disp_free_valid  = nx_v[2];
    disp_free_id     = nx_d[2][EW-1 -: IW];
    disp_free_fail   = nx_d[2][RW];
    disp_free_reason = nx_d[2][RW-1:0];
    ortree_free_valid  = nx_v[3];
    ortree_free_id     = nx_d[3][EW-1 -: IW];
    ortree_free_fail   = nx_d[3][RW];
    ortree_free_reason = nx_d[3][RW-1:0];
    alloc_rsp_fifo_full = full_m[0];
    free_rsp_fifo_full  = full_m[1];
    // Grant decision uses the queues as they stand at the start of the cycle.
    for (int ch = 0; ch < 2; ch++) begin
      if (!full_m[ch] && (mq[2*ch].size() > 0 || mq[2*ch+1].size() > 0)) begin
        if (mq[2*ch].size() > 0 && mq[2*ch+1].size() > 0) g = last_eng[ch] ? 0 : 1;
        else g = (mq[2*ch].size() > 0) ? 0 : 1;
        last_eng[ch] = (g == 1);
        d = mq[2*ch+g].pop_front();
        exp_q[ch].push_back('{cyc + 1, d});
      end
    end
    // Pushes after the pop: a same-cycle pop makes room in a full queue.
    for (int i = 0; i < 4; i++) begin
      if (nx_v[i]) begin
        d = nx_d[i];
        if (i >= 2) d[RW+1 +: PW] = '0;
        if (mq[i].size() < DEPTH) mq[i].push_back(d);
        else ovf_m[i] = 1'b1;
      end
    end
    nx_v = '0;
    for (int i = 0; i < 4; i++) nx_d[i] = EW'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    disp_alloc_valid = 1'b0; fdt_alloc_valid = 1'b0;
    disp_free_valid = 1'b0; ortree_free_valid = 1'b0;
    nx_v = '0;
    for (int i = 0; i < 4; i++) mq[i].delete();
    exp_q[0].delete();
    exp_q[1].delete();
    last_eng = 2'b11;
    ovf_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: sample just after each rising edge and compare against the model.
  initial begin
    logic          exp_we, act_we, any_we;
    logic [EW-1:0] act_d;
    logic [PW-1:0] zero_pg;
    zero_pg = '0;
    forever begin
      @(posedge clk);
      #1;
      any_we = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        while (exp_q[ch].size() > 0 && exp_q[ch][0].cyc < cyc) begin
          checks++; errors++;
          $display("FAIL missed_write ch=%0d cyc=%0d: actual none, required data=%h due cyc %0d",
                   ch, cyc, exp_q[ch][0].d, exp_q[ch][0].cyc);
          void'(exp_q[ch].pop_front());
        end
        exp_we = (exp_q[ch].size() > 0) && (exp_q[ch][0].cyc == cyc);
        any_we = any_we | exp_we;
        act_we = (ch == 0) ? alloc_rsp_write_en : free_rsp_write_en;
        act_d  = (ch == 0) ? {alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason}
                           : {free_rsp_id, zero_pg, free_rsp_fail, free_rsp_fail_reason};
        checks++;
        if (act_we !== exp_we) begin
          errors++;
          $display("FAIL write_en ch=%0d cyc=%0d: actual %b, required %b", ch, cyc, act_we, exp_we);
          if (exp_we) void'(exp_q[ch].pop_front());
        end else if (exp_we) begin
          checks++;
          if (act_d !== exp_q[ch][0].d) begin
            errors++;
            $display("FAIL write_data ch=%0d cyc=%0d: actual %h, required %h",
                     ch, cyc, act_d, exp_q[ch][0].d);
          end
          void'(exp_q[ch].pop_front());
        end else begin
          checks++;
          if (act_d !== '0) begin
            errors++;
            $display("FAIL idle_data ch=%0d cyc=%0d: actual %h, required 0", ch, cyc, act_d);
          end
        end
      end
      checks++;
      if (overflow_err !== ovf_m) begin
        errors++;
        $display("FAIL overflow_err cyc=%0d: actual %b, required %b", cyc, overflow_err, ovf_m);
      end
      checks++;
      if (arb_idle !== (mq[0].size() == 0 && mq[1].size() == 0 && mq[2].size() == 0 &&
                        mq[3].size() == 0 && !any_we)) begin
        errors++;
        $display("FAIL arb_idle cyc=%0d: actual %b, required %b", cyc, arb_idle, !arb_idle);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    disp_alloc_valid = 1'b0; fdt_alloc_valid = 1'b0;
    disp_free_valid = 1'b0; ortree_free_valid = 1'b0;
    alloc_rsp_fifo_full = 1'b0; free_rsp_fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) nx_d[i] = EW'($urandom);
    {disp_alloc_id, disp_alloc_page_idx, disp_alloc_fail, disp_alloc_reason} = nx_d[0];
    {fdt_alloc_id, fdt_alloc_page_idx, fdt_alloc_fail, fdt_alloc_reason} = nx_d[1];
    {disp_free_id, disp_free_fail, disp_free_reason} = '0;
    {ortree_free_id, ortree_free_fail, ortree_free_reason} = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single path through the FDT alloc queue.
    repeat (3) tick();
    set_push(1, 8'h12, 8'h40, 1'b0, 3'd0);
    tick();
    repeat (5) tick();

    // Collision and fairness on the alloc channel.
    set_push(0, 8'd1, 8'h11, 1'b0, 3'd0);
    set_push(1, 8'd2, 8'h22, 1'b1, 3'd2);
    tick();
    set_push(0, 8'd3, 8'h33, 1'b0, 3'd0);
    set_push(1, 8'd4, 8'h44, 1'b1, 3'd1);
    tick();
    repeat (7) tick();

    // Backpressure on the alloc channel.
    full_m[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      set_push(1, 8'(k), 8'(k + 8'h50), 1'b0, 3'd0);
      tick();
    end
    repeat (5) tick();
    full_m[0] = 1'b0;
    repeat (6) tick();

    // Overflow on the or_tree free queue.
    full_m[1] = 1'b1;
    for (int k = 10; k <= 14; k++) begin
      set_push(3, 8'(k), 8'h00, 1'b1, 3'd3);
      tick();
    end
    tick();
    full_m[1] = 1'b0;
    repeat (8) tick();

    // All four producers at once straight after reset.
    do_reset();
    set_push(0, 8'hA0, 8'h01, 1'b0, 3'd0);
    set_push(1, 8'hA1, 8'h02, 1'b1, 3'd1);
    set_push(2, 8'hB0, 8'h00, 1'b0, 3'd0);
    set_push(3, 8'hB1, 8'h00, 1'b1, 3'd2);
    tick();
    repeat (6) tick();

    // Reset with entries still queued behind a full downstream FIFO.
    full_m[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_push(k % 2, 8'(8'h60 + k), 8'(k), 1'b0, 3'd0);
      tick();
    end
    do_reset();
    full_m[0] = 1'b0;
    repeat (6) tick();

    // Randomized traffic with random downstream backpressure.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(99) < 40) begin
          nx_v[i] = 1'b1;
          nx_d[i] = EW'($urandom);
        end
      end
      full_m[0] = ($urandom_range(99) < 25);
      full_m[1] = ($urandom_range(99) < 25);
      tick();
      if (n == 1500) do_reset();
    end

    // Drain and confirm nothing is left outstanding.
    full_m = '0;
    repeat (15) tick();
    @(negedge clk);
    checks++;
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0 || mq[0].size() != 0 ||
        mq[1].size() != 0 || mq[2].size() != 0 || mq[3].size() != 0) begin
      errors++;
      $display("FAIL drain: actual %0d/%0d writes outstanding, required 0/0",
               exp_q[0].size(), exp_q[1].size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
